refresh_executor: RTL
=====================

# refresh_executor

Command-generator-side consumer of refresh grants. It queues `ref_do` pulses from the refresh timing controller and closes all open banks with a PRECHARGE-ALL when needed. It then issues the REFRESH command on the command bus and blocks activates for tRP/tRFC. Towards the refresh timing controller it raises `ref_req` when the scheduler is idle, so refreshes are pulled in early.

## Interface
- `T_RP`, default 6: PRECHARGE-ALL to REFRESH spacing, clk cycles (≥1).
- `T_RFC`, default 88: REFRESH to next command spacing, clk cycles (≥1).
- `MAX_PEND`, default 8: depth of the pending-refresh counter.
- `clk`  in  1: controller clock; everything is synchronous to its rising edge.
- `rstn`  in  1: reset; one clock, reset is asynchronous and active-low.
- `ref_do`  in  1: refresh grant, one-cycle pulse in the `clk` domain.
- `warning`  in  4: postponed-refresh count from the refresh timing controller.
- `sched_idle`  in  1: scheduler has no queued read/write work.
- `banks_open`  in  8: one bit per bank, 1 = row open.
- `ref_req`  out  1: early-refresh request to the refresh timing controller.
- `cmd_valid`  out  1: command offer to the command-bus arbiter.
- `cmd_type`  out  2: 00 NOP, 01 PREA, 10 REF.
- `cmd_ready`  in  1: arbiter accepts the command in this cycle.
- `busy`  out  1: scheduler must not issue ACT/RD/WR.
- `urgent`  out  1: `warning` ≥ 6 or `pending` ≥ 6; arbiter gives top priority.
- `overflow`  out  1: sticky error, `ref_do` arrived while `pending` == `MAX_PEND`.

## Operation
- `pending` is a 4-bit counter.
  - +1 on `ref_do`.
  - −1 on REF acceptance.
  - If both happen in the same cycle, it is unchanged.
  - When full, a new `ref_do` is dropped and sets `overflow`. Only `rstn` clears `overflow`.
- FSM states: IDLE, PREA, WAIT_RP, REF, WAIT_RFC.
- IDLE → PREA when `pending` > 0 and `banks_open` ≠ 0.
- IDLE → REF when `pending` > 0 and `banks_open` == 0.
- PREA: `cmd_valid`=1, `cmd_type`=01, held until `cmd_ready`. Acceptance → WAIT_RP, timer loaded with `T_RP`−1.
- WAIT_RP: timer counts down to 0, then → REF.
- REF: `cmd_valid`=1, `cmd_type`=10, held until `cmd_ready`. Acceptance → WAIT_RFC, timer loaded with `T_RFC`−1, `pending` decremented.
- WAIT_RFC: timer reaches 0 → IDLE.
- Back-to-back refreshes: after WAIT_RFC the FSM always returns to IDLE. The next refresh re-evaluates `banks_open`, which is normally 0, so PREA is skipped.
- `busy` = 1 in every state except IDLE. It is also 1 in IDLE whenever `pending` > 0.
- `cmd_type` = 00 whenever `cmd_valid` = 0.
- Offer stability: `cmd_valid`/`cmd_type` never change while an offer is outstanding and `cmd_ready` is low. Changes in `banks_open` during PREA are ignored.
- `ref_req` is registered. It is 1 when state is IDLE, `pending` == 0, `sched_idle` == 1 and `warning` < 8, otherwise 0. It deasserts on the cycle after `ref_do` is seen.

## Timing
- Reset values: FSM = IDLE, `pending` = 0, timer = 0, `ref_req` = 0, `cmd_valid` = 0, `cmd_type` = 00, `busy` = 0, `urgent` = 0, `overflow` = 0.
- Registered outputs: `cmd_valid`, `cmd_type`, `ref_req`, `overflow`. `busy` and `urgent` are combinational from registers and inputs.
- `ref_do` at cycle N:
  - `pending` = 1 at N+1.
  - `busy` = 1 at N+1.
  - `cmd_valid` = 1 at N+2, with PREA or REF.
- PREA accepted at cycle A: REF is offered first at cycle A+`T_RP`.
- REF accepted at cycle B:
  - `busy` stays 1 through B+`T_RFC`−1.
  - FSM is in IDLE at B+`T_RFC`.
  - `busy` = 0 at B+`T_RFC` if `pending` == 0.
- Reset mid-operation: all state returns to reset values immediately, with no partial command. An outstanding offer is withdrawn.

## Test plan
- Reset, then one `ref_do` with `banks_open`=0, `cmd_ready`=1, `T_RFC`=88:
  - REF offered 2 cycles after the pulse.
  - `busy` high for exactly 88 cycles after acceptance.
  - `pending` returns to 0.
- `banks_open`=8'h05, `ref_do`, `cmd_ready`=1, `T_RP`=6: PREA then REF, with REF accepted exactly 6 cycles after PREA acceptance.
- `cmd_ready` held low for 10 cycles during the REF offer: `cmd_valid`/`cmd_type` stable at 1/10 for all 10 cycles. The timer starts only at acceptance.
- 9 `ref_do` pulses with `cmd_ready`=0:
  - `pending` saturates at 8 and `overflow` = 1.
  - `urgent` = 1 once `pending` ≥ 6.
  - `overflow` stays 1 after the refreshes drain.
- `ref_do` in the same cycle as REF acceptance with `pending`=3: `pending` stays 3.
- `sched_idle`=1 with `pending`=0 and `warning`=2:
  - `ref_req`=1.
  - After `ref_do`, `ref_req`=0 the next cycle.
  - `rstn` pulsed low mid WAIT_RFC gives all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/refresh_executor.sv
// rtl/refresh_executor.sv - refresh grant consumer: queues grants, issues PREA/REF, blocks ACT for tRP/tRFC
module refresh_executor #(
   parameter int T_RP     = 6,
   parameter int T_RFC    = 88,
   parameter int MAX_PEND = 8
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_ref_do,
   input  logic [3:0] i_warning,
   input  logic       i_sched_idle,
   input  logic [7:0] i_banks_open,
   output logic       o_ref_req,
   output logic       o_cmd_valid,
   output logic [1:0] o_cmd_type,
   input  logic       i_cmd_ready,
   output logic       o_busy,
   output logic       o_urgent,
   output logic       o_overflow
);

   localparam int T_MAX = (T_RFC > T_RP) ? T_RFC : T_RP;
   localparam int TW    = $clog2(T_MAX + 1);

   localparam logic [1:0] CMD_NOP  = 2'b00;
   localparam logic [1:0] CMD_PREA = 2'b01;
   localparam logic [1:0] CMD_REF  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREA,
      S_WAIT_RP,
      S_REF,
      S_WAIT_RFC
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [TW-1:0]   r_timer;
   logic [TW-1:0]   w_timer_nxt;
   logic [3:0]      r_pending;
   logic [3:0]      w_pending_nxt;
   logic            r_cmd_valid;
   logic [1:0]      r_cmd_type;
   logic            r_ref_req;
   logic            r_overflow;
   logic            w_full;
   logic            w_ref_acc;
   logic            w_inc;

   // A grant arriving while full is still absorbed if a REF retires in the same cycle.
   always_comb begin
      w_full    = (r_pending == 4'(MAX_PEND));
      w_ref_acc = (r_state == S_REF) && i_cmd_ready;
      w_inc     = i_ref_do && (!w_full || w_ref_acc);
      w_pending_nxt = r_pending;
      if (w_inc && !w_ref_acc)
         w_pending_nxt = r_pending + 4'd1;
      else if (!w_inc && w_ref_acc)
         w_pending_nxt = r_pending - 4'd1;
   end

   // Wait states leave one cycle early so the next offer lands exactly tRP/tRFC after acceptance.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      case (r_state)
         S_IDLE: begin
            if (r_pending != 4'd0)
               w_state_nxt = (i_banks_open != 8'd0) ? S_PREA : S_REF;
         end
         S_PREA: begin
            if (i_cmd_ready) begin
               if (T_RP > 1) begin
                  w_state_nxt = S_WAIT_RP;
                  w_timer_nxt = TW'(T_RP - 1);
               end else begin
                  w_state_nxt = S_REF;
                  w_timer_nxt = '0;
               end
            end
         end
         S_WAIT_RP: begin
            if (r_timer <= TW'(1)) begin
               w_state_nxt = S_REF;
               w_timer_nxt = '0;
            end else begin
               w_timer_nxt = r_timer - TW'(1);
            end
         end
         S_REF: begin
            if (i_cmd_ready) begin
               if (T_RFC > 1) begin
                  w_state_nxt = S_WAIT_RFC;
                  w_timer_nxt = TW'(T_RFC - 1);
               end else begin
                  w_state_nxt = S_IDLE;
                  w_timer_nxt = '0;
               end
            end
         end
         S_WAIT_RFC: begin
            if (r_timer <= TW'(1)) begin
               w_state_nxt = S_IDLE;
               w_timer_nxt = '0;
            end else begin
               w_timer_nxt = r_timer - TW'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state     <= S_IDLE;
         r_timer     <= '0;
         r_pending   <= 4'd0;
         r_cmd_valid <= 1'b0;
         r_cmd_type  <= CMD_NOP;
         r_ref_req   <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_timer     <= w_timer_nxt;
         r_pending   <= w_pending_nxt;
         r_cmd_valid <= (w_state_nxt == S_PREA) || (w_state_nxt == S_REF);
         r_cmd_type  <= (w_state_nxt == S_PREA) ? CMD_PREA :
                        (w_state_nxt == S_REF)  ? CMD_REF  : CMD_NOP;
         // Built from next-cycle values so a grant drops the request immediately.
         r_ref_req   <= (w_state_nxt == S_IDLE) && (w_pending_nxt == 4'd0) &&
                        i_sched_idle && (i_warning < 4'd8);
         if (i_ref_do && !w_inc)
            r_overflow <= 1'b1;
      end
   end

   assign o_cmd_valid = r_cmd_valid;
   assign o_cmd_type  = r_cmd_type;
   assign o_ref_req   = r_ref_req;
   assign o_overflow  = r_overflow;
   assign o_busy      = (r_state != S_IDLE) || (r_pending != 4'd0);
   assign o_urgent    = (i_warning >= 4'd6) || (r_pending >= 4'd6);

endmodule
